// File: rtl/tros_pkg.sv
// Purpose: shared constants, FSM state type and CRC-8 step for the ring-oscillator readout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tros_pkg;

    localparam int                    TROS_HDR_W     = 4;
    localparam logic [TROS_HDR_W-1:0] TROS_HDR       = 4'b1010;
    localparam logic [7:0]            TROS_CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        GAP,
        DONE
    } tros_state_t;

    // One serial step of CRC-8, MSB-first, no reflection.
    function automatic logic [7:0] tros_crc8_step(input logic [7:0] crc, input logic din);
        return {crc[6:0], 1'b0} ^ (((crc[7] ^ din) == 1'b1) ? TROS_CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/tros_sync2.sv
// Purpose: 2-FF synchroniser for asynchronous pin levels (latch and other ui_in pins).
// Latency: 2 enabled clk edges from d to q.
// Backpressure: none; ena low freezes both flops.
// Ports: clk, reset (async active-high), ena (clock enable), d (async input), q (synchronised output).
module tros_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic ena,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else if (ena) begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tros_scan_readout.sv
// Purpose: coherent snapshot of NUM_CH oscillator counters, serialised as framed words on one pin.
// Latency: first header bit 4 enabled cycles after latch is first sampled high (sync, edge, CAPTURE).
// Backpressure: none; ena low freezes everything, latch edges while busy or in DONE are dropped.
// Ports: clk, reset (async active-high), ena, latch (async pin), mode (0 single / 1 scan),
//        chan_sel, counts (channel i at [i*COUNTER_LENGTH +: COUNTER_LENGTH]),
//        serial_out (MSB first), frame_start, busy, done.
// Frame: 1010 | channel index (CH_W) | count (COUNTER_LENGTH) [| CRC-8 when TROS_READOUT_CRC8_EN].
module tros_scan_readout
    import tros_pkg::*;
#(
    parameter  int NUM_CH         = 4,
    parameter  int COUNTER_LENGTH = 20,
    parameter  int GAP_CYCLES     = 2,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ena,
    input  logic                             latch,
    input  logic                             mode,
    input  logic [CH_W-1:0]                  chan_sel,
    input  logic [NUM_CH*COUNTER_LENGTH-1:0] counts,
    output logic                             serial_out,
    output logic                             frame_start,
    output logic                             busy,
    output logic                             done
);

    localparam int CL = COUNTER_LENGTH;
    localparam int FB = TROS_HDR_W + CH_W + CL;   // frame bits held in the shift register
`ifdef TROS_READOUT_CRC8_EN
    localparam int CRC_W = 8;
`else
    localparam int CRC_W = 0;
`endif
    localparam int F  = FB + CRC_W;
    localparam int BW = $clog2(F + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    tros_state_t              state;
    logic [NUM_CH*CL-1:0]     snap;
    logic [CH_W-1:0]          ptr;
    logic                     mode_r;
    logic [FB-1:0]            sreg;
    logic [BW-1:0]            bit_cnt;
    logic [GW-1:0]            gap_cnt;
    logic                     latch_s;
    logic                     latch_d;
    logic                     latch_rise;

    tros_sync2 u_latch_sync (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .d     (latch),
        .q     (latch_s)
    );

    assign latch_rise = latch_s & ~latch_d;

    // Next frame to load: in CAPTURE straight from the live counts (the snapshot is
    // written on the same edge), afterwards from the snapshot at the next channel.
    logic [CH_W-1:0]      ld_idx;
    logic [NUM_CH*CL-1:0] ld_src;
    logic [CL-1:0]        ld_cnt;
    logic [FB-1:0]        ld_word;

    always_comb begin
        ld_idx = ptr + 1'b1;
        ld_src = snap;
        if (state == CAPTURE) begin
            ld_idx = mode ? '0 : chan_sel;
            ld_src = counts;
        end
        // Indices with no channel behind them carry an all-zero count.
        ld_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ld_idx == CH_W'(i)) begin
                ld_cnt = ld_src[i*CL +: CL];
            end
        end
        ld_word = {TROS_HDR, ld_idx, ld_cnt};
    end

    logic bit_last;
    logic gap_last;
    logic last_ch;
    logic start_frame;

    assign bit_last = (bit_cnt == BW'(F - 1));
    assign gap_last = (gap_cnt == GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0));
    assign last_ch  = !mode_r || (ptr == CH_W'(NUM_CH - 1));

    // With no gap the next frame follows the previous one back to back.
    assign start_frame = (state == CAPTURE)
                      || ((state == GAP) && gap_last)
                      || ((state == SHIFT) && bit_last && !last_ch && (GAP_CYCLES == 0));

`ifdef TROS_READOUT_CRC8_EN
    logic [7:0] crc;
    logic       in_payload;
    logic [7:0] crc_nx;

    // The bit currently on the pin is folded in when it belongs to index or count.
    assign in_payload = (bit_cnt >= BW'(TROS_HDR_W)) && (bit_cnt < BW'(FB));
    assign crc_nx     = in_payload ? tros_crc8_step(crc, serial_out) : crc;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            snap        <= '0;
            ptr         <= '0;
            mode_r      <= 1'b0;
            sreg        <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            latch_d     <= 1'b0;
            serial_out  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef TROS_READOUT_CRC8_EN
            crc         <= '0;
`endif
        end else if (ena) begin
            latch_d     <= latch_s;
            frame_start <= 1'b0;
            done        <= 1'b0;

            case (state)
                IDLE: begin
                    if (latch_rise) begin
                        state <= CAPTURE;
                        busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    snap   <= counts;
                    mode_r <= mode;
                end
                SHIFT: begin
                    if (bit_last) begin
                        serial_out <= 1'b0;
                        if (last_ch) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
`ifdef TROS_READOUT_CRC8_EN
                        // Past the count field the CRC register itself is shifted out.
                        if (bit_cnt >= BW'(FB - 1)) begin
                            serial_out <= crc_nx[7];
                            crc        <= {crc_nx[6:0], 1'b0};
                        end else begin
                            serial_out <= sreg[FB-1];
                            sreg       <= sreg << 1;
                            crc        <= crc_nx;
                        end
`else
                        serial_out <= sreg[FB-1];
                        sreg       <= sreg << 1;
`endif
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Frame load overrides the per-state updates above.
            if (start_frame) begin
                state       <= SHIFT;
                ptr         <= ld_idx;
                serial_out  <= ld_word[FB-1];
                sreg        <= ld_word << 1;
                bit_cnt     <= '0;
                frame_start <= 1'b1;
`ifdef TROS_READOUT_CRC8_EN
                crc         <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_tros_scan_readout.sv
`timescale 1ns/1ps
module tb_tros_scan_readout;

`ifdef TROS_READOUT_CRC8_EN
    localparam int NCH  = 8;
    localparam int CRCW = 8;
`else
    localparam int NCH  = 4;
    localparam int CRCW = 0;
`endif
    localparam int CL  = 20;
    localparam int GAP = 2;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int FL  = 4 + CHW + CL + CRCW;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                ena = 1'b1;
    logic                latch = 1'b0;
    logic                mode = 1'b0;
    logic [CHW-1:0]      chan_sel = '0;
    logic [NCH*CL-1:0]   counts = '0;
    logic                serial_out;
    logic                frame_start;
    logic                busy;
    logic                done;

    always #5 clk = ~clk;

    tros_scan_readout #(
        .NUM_CH         (NCH),
        .COUNTER_LENGTH (CL),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ena         (ena),
        .latch       (latch),
        .mode        (mode),
        .chan_sel    (chan_sel),
        .counts      (counts),
        .serial_out  (serial_out),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected {serial_out, frame_start, busy, done}, one entry per enabled cycle.
    logic [3:0]  q[$];
    logic [3:0]  cur = 4'b0000;
    logic [63:0] rec_frames[$];
    int          busy_cnt = 0;
    int          done_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // CRC-8, poly 0x07, init 0, MSB-first over the low n bits of 'bits'.
    function automatic logic [7:0] crc8_sw(input logic [63:0] bits, input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[7] ^ bits[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [63:0] model_frame(input int c, input logic [CL-1:0] v);
        logic [63:0] pl;
        logic [63:0] w;
        pl = (64'(c) << CL) | 64'(v);
        pl = pl & ((64'd1 << (CHW + CL)) - 1);
        w  = (64'h0A << (CHW + CL)) | pl;
        if (CRCW > 0) w = (w << 8) | 64'(crc8_sw(pl, CHW + CL));
        return w;
    endfunction

    function automatic logic [CL-1:0] chan_count(input int c);
        logic [CL-1:0] v;
        v = '0;
        if (c < NCH) v = counts[c*CL +: CL];
        return v;
    endfunction

    function automatic logic [63:0] get_frame(input int i);
        if (rec_frames.size() > i) return rec_frames[i];
        return '1;
    endfunction

    task automatic push_readout(input logic m, input int sel);
        int          first;
        int          last;
        logic [63:0] w;
        repeat (2) q.push_back(4'b0000);      // synchroniser + edge detect
        q.push_back(4'b0010);                  // CAPTURE
        first = m ? 0 : sel;
        last  = m ? NCH - 1 : sel;
        for (int c = first; c <= last; c++) begin
            w = model_frame(c, chan_count(c));
            for (int i = FL - 1; i >= 0; i--) q.push_back({w[i], (i == FL - 1), 1'b1, 1'b0});
            if (c != last) repeat (GAP) q.push_back(4'b0010);
        end
        q.push_back(4'b0001);                  // DONE
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic m, input int sel);
        mode     = m;
        chan_sel = CHW'(sel);
        push_readout(m, sel);
        latch    = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((q.size() != 0 || busy || done) && k < 2000) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k >= 2000) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d cycles required < 2000", name, k);
        end
        repeat (2) tick();
    endtask

    // Per-cycle compare and frame recorder.
    initial begin
        logic       ena_s;
        logic [3:0] exp_v;
        logic [63:0] rec_w;
        int         rec_len;
        rec_w   = '0;
        rec_len = 0;
        forever begin
            @(posedge clk);
            ena_s = ena;
            if (reset) cur = 4'b0000;
            else if (ena) cur = (q.size() > 0) ? q.pop_front() : 4'b0000;
            @(negedge clk);
            exp_v = reset ? 4'b0000 : cur;
            n_cmp++;
            if ({serial_out, frame_start, busy, done} !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_outputs t=%0t: got so/fs/busy/done=%b required %b",
                         $time, {serial_out, frame_start, busy, done}, exp_v);
            end
            if (reset) begin
                rec_len = 0;
            end else if (ena_s) begin
                if (frame_start) begin
                    rec_w   = 64'(serial_out);
                    rec_len = 1;
                end else if (rec_len > 0) begin
                    rec_w   = {rec_w[62:0], serial_out};
                    rec_len++;
                end
                if (rec_len == FL) begin
                    rec_frames.push_back(rec_w);
                    rec_len = 0;
                end
                if (busy) busy_cnt++;
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        logic [63:0] w;
        logic [63:0] lit;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({serial_out, frame_start, busy, done}), 64'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Single channel 2 = 0xABCDE.
        for (int c = 0; c < NCH; c++) counts[c*CL +: CL] = CL'(32'h1000 * (c + 7));
        counts[2*CL +: CL] = 20'hABCDE;
        rec_frames.delete();
        done_cnt = 0;
        fire(1'b0, 2);
        repeat (4) tick();
        latch = 1'b0;
        wait_idle("t1");
        check("t1_frames", 64'(rec_frames.size()), 64'd1);
        check("t1_done_pulses", 64'(done_cnt), 64'd1);
`ifndef TROS_READOUT_CRC8_EN
        lit = 64'(26'b1010_10_1010_1011_1100_1101_1110);
        check("t1_model_pin", model_frame(2, 20'hABCDE), lit);
        check("t1_literal", get_frame(0), lit);
`endif

        // Scan, channel c carries c+1.
        for (int c = 0; c < NCH; c++) counts[c*CL +: CL] = CL'(c + 1);
        rec_frames.delete();
        busy_cnt = 0;
        fire(1'b1, 0);
        repeat (4) tick();
        latch = 1'b0;
        wait_idle("t2");
        check("t2_frames", 64'(rec_frames.size()), 64'(NCH));
        check("t2_busy_cycles", 64'(busy_cnt), 64'(1 + NCH * FL + (NCH - 1) * GAP));
`ifndef TROS_READOUT_CRC8_EN
        check("t2_busy_literal", 64'(busy_cnt), 64'd111);
`endif
        for (int c = 0; c < NCH; c++) begin
            w = get_frame(c);
            check("t2_index", 64'(w[CRCW + CL +: CHW]), 64'(c));
            check("t2_count", 64'(w[CRCW +: CL]), 64'(c + 1));
        end

        // Counter changes after CAPTURE must not reach the frame.
        counts[1*CL +: CL] = 20'd5;
        rec_frames.delete();
        fire(1'b1, 0);
        repeat (4) tick();
        latch = 1'b0;
        repeat (6) tick();
        counts[1*CL +: CL] = 20'd9;
        wait_idle("t3");
        w = get_frame(1);
        check("t3_frozen_count", 64'(w[CRCW +: CL]), 64'd5);

        // Extra latch edge mid-scan is ignored; latch held high does not retrigger.
        done_cnt = 0;
        fire(1'b1, 0);
        repeat (4) tick();
        latch = 1'b0;
        repeat (30) tick();
        latch = 1'b1;
        wait_idle("t4a");
        check("t4_one_done", 64'(done_cnt), 64'd1);
        repeat (10) tick();
        check("t4_no_restart_busy", 64'(busy), 64'd0);
        check("t4_no_restart_done", 64'(done_cnt), 64'd1);
        latch = 1'b0;
        repeat (3) tick();
        fire(1'b0, 1);
        repeat (4) tick();
        latch = 1'b0;
        wait_idle("t4b");
        check("t4_second_done", 64'(done_cnt), 64'd2);

        // ena stall mid-frame.
        counts[2*CL +: CL] = 20'hABCDE;
        rec_frames.delete();
        fire(1'b0, 2);
        repeat (4) tick();
        latch = 1'b0;
        repeat (11) tick();
        ena = 1'b0;
        repeat (10) tick();
        ena = 1'b1;
        wait_idle("t5a");
        check("t5_stall_frame", get_frame(0), model_frame(2, 20'hABCDE));

        // Reset mid-frame, then a clean readout.
        fire(1'b1, 0);
        repeat (4) tick();
        latch = 1'b0;
        repeat (16) tick();
        reset = 1'b1;
        q.delete();
        #1;
        check("t5_reset_abort", 64'({serial_out, frame_start, busy, done}), 64'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        rec_frames.delete();
        fire(1'b0, 2);
        repeat (4) tick();
        latch = 1'b0;
        wait_idle("t5b");
        check("t5_after_reset", get_frame(0), model_frame(2, 20'hABCDE));

`ifdef TROS_READOUT_CRC8_EN
        // Channel 5 with zero count, CRC over index+count.
        counts[5*CL +: CL] = '0;
        rec_frames.delete();
        fire(1'b0, 5);
        repeat (4) tick();
        latch = 1'b0;
        wait_idle("t6");
        w = get_frame(0);
        check("t6_header", 64'(w[FL-1 -: 4]), 64'hA);
        check("t6_index", 64'(w[8 + CL +: CHW]), 64'd5);
        check("t6_count", 64'(w[8 +: CL]), 64'd0);
        check("t6_crc", 64'(w[7:0]), 64'(crc8_sw((64'd5 << CL), CHW + CL)));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
